piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shift unit with serial fill input. It supersedes the single-mode shift/load register. It adds:
- a valid/ready load handshake
- a bit counter with an end-of-word pulse
- selectable fill modes: logical, arithmetic, rotate
- selectable bit order
- stall and abort controls

It sits between a parallel word producer and a bit-serial link or sink.

Parameters:
- WIDTH, 8, shift register width in bits; must be at least 2.
- LSB_FIRST, 1, 1 = shift right and emit bit 0 first; 0 = shift left and emit bit WIDTH-1 first.

Ports:
- clk  input  1  clock, rising edge
- rst_b  input  1  reset, asynchronous, active-low
- load_valid  input  1  producer offers data_in/mode
- load_ready  output  1  unit can accept a word (combinational: state==IDLE)
- data_in  input  WIDTH  parallel word
- mode  input  2  fill mode, sampled at load: 00 logical (fill = ser_in), 01 arithmetic, 10 rotate, 11 zero fill
- ser_in  input  1  serial fill bit, used in mode 00
- shift_en  input  1  advance one bit this cycle when in SHIFT
- abort  input  1  synchronous abandon of the current word
- bit_out  output  1  emitted serial bit (registered)
- bit_valid  output  1  bit_out holds a new bit this cycle
- done  output  1  one-cycle pulse, coincident with the last bit_valid of a word
- busy  output  1  state==SHIFT
- count  output  $clog2(WIDTH+1)  bits emitted for the current word
- data_out  output  WIDTH  current shift register contents

Behaviour:
- Reset (async, rst_b=0):
  - state = IDLE
  - data_out = 0, bit_out = 0, bit_valid = 0, done = 0, count = 0
  - stored mode = 00
  - bit_out is driven 0 when invalid, never z.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1: data_out<=data_in, latch mode, count<=0, next state SHIFT.
  - bit_valid and done are 0 on every edge that is not a shift.
- SHIFT:
  - load_ready=0; load_valid is ignored.
  - On an edge with shift_en=1 and abort=0:
    - bit_out<=out_bit and bit_valid<=1.
    - out_bit = data_out[0] if LSB_FIRST, else data_out[WIDTH-1].
    - Register shifts one place; the vacated end takes the fill bit.
    - count<=count+1.
- SHIFT with shift_en=0: register, count and bit_out hold; bit_valid<=0 (stall).
- Fill bit by latched mode:
  - 00: ser_in.
  - 01: LSB_FIRST=1 replicates data_out[WIDTH-1] (sign extend); LSB_FIRST=0 fills 0.
  - 10: out_bit (rotate).
  - 11: 0.
- Last bit (shift edge where count==WIDTH-1):
  - done<=1 together with bit_valid<=1.
  - count<=WIDTH.
  - next state IDLE, so load_ready=1 in the following cycle.
  - Minimum word period is WIDTH+1 cycles (1 load + WIDTH shifts).
- abort=1 in SHIFT has priority over shift_en:
  - next state IDLE, bit_valid<=0, done<=0, count<=0.
  - data_out is kept as is.
- abort in IDLE: no effect; a simultaneous load is accepted.
- count is held after done until the next accepted load clears it.
- Reset asserted mid-word: immediate return to reset values; the partial word is lost and no done is produced.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SHIFT)
  - mode encodings (MODE_LOGIC=2'b00, MODE_ARITH=2'b01, MODE_ROT=2'b10, MODE_ZERO=2'b11)
  - a function computing the count width
- Single natural sub-module: shift_core.
  - Contains the register, the fill-bit mux and the LSB_FIRST direction.
  - Has load/shift enables and exposes out_bit.
  - The FSM, counter and handshake remain in piso_serializer.

Test Plan:
- Reset values: WIDTH=8, LSB_FIRST=1, hold rst_b=0 -> all outputs 0, load_ready=1; release, no load_valid -> busy stays 0.
- Logical mode: load 0xA5, mode 00, ser_in=0, shift_en=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles; done on the 8th; data_out=0x00; count=8; load_ready=1 the next cycle.
- Rotate and arithmetic: load 0xA5, mode 10 -> after done, data_out=0xA5. Load 0x80, mode 01 -> bits 0×7 then 1, final data_out=0xFF. With LSB_FIRST=0, load 0x81, mode 01 -> bits 1,0,0,0,0,0,0,1, data_out=0x00.
- Stall: shift_en toggles 1,0,0,1,... during word 0x3C -> bit_valid low in stalled cycles; bit sequence unchanged; done after exactly 8 valid bits.
- Abort and load-ignore: load 0xFF, abort after 3 bits -> bit_valid=0, count=0, no done, data_out=0x1F (mode 00, ser_in=0). load_valid held high during SHIFT -> no capture until IDLE.
- Async reset mid-word: rst_b pulsed low between clock edges after 4 bits of 0xF0 -> outputs 0 immediately; next load 0x01 serializes cleanly with done after 8 bits.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MODE_LOGIC = 2'b00,
      MODE_ARITH = 2'b01,
      MODE_ROT   = 2'b10,
      MODE_ZERO  = 2'b11
   } fill_mode_t;

   // Width of a counter that must reach the value w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/piso_serializer_shift_core.sv
// Shift register datapath: parallel load, one-place shift in the configured
// direction, and fill-bit selection for the vacated end.
module piso_serializer_shift_core
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load_en,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] data_in,
   input  fill_mode_t       fill_mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_bit
);

   logic             fill_bit;
   logic [WIDTH-1:0] shifted;

   assign out_bit = LSB_FIRST ? data_out[0] : data_out[WIDTH-1];

   // Select the bit entering the vacated end; arithmetic fill only
   // sign-extends when shifting right, a left shift has no sign to copy.
   always_comb begin
      fill_bit = 1'b0;
      case (fill_mode)
         MODE_LOGIC: fill_bit = ser_in;
         MODE_ARITH: fill_bit = LSB_FIRST ? data_out[WIDTH-1] : 1'b0;
         MODE_ROT:   fill_bit = out_bit;
         MODE_ZERO:  fill_bit = 1'b0;
         default:    fill_bit = 1'b0;
      endcase
   end

   // Next register value for a one-place shift.
   always_comb begin
      shifted = data_out;
      if (LSB_FIRST)
         shifted = {fill_bit, data_out[WIDTH-1:1]};
      else
         shifted = {data_out[WIDTH-2:0], fill_bit};
   end

   // Register update: load wins over shift; the FSM never asserts both.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         data_out <= '0;
      else if (load_en)
         data_out <= data_in;
      else if (shift_en)
         data_out <= shifted;
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, bit counter,
// end-of-word pulse, selectable fill mode, stall and abort.
//
//  state | meaning
//  IDLE  | waiting for a word; load_ready high
//  SHIFT | emitting bits; advances on shift_en, abort returns to IDLE
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_b,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [WIDTH-1:0]              data_in,
   input  logic [1:0]                    mode,
   input  logic                          ser_in,
   input  logic                          shift_en,
   input  logic                          abort,
   output logic                          bit_out,
   output logic                          bit_valid,
   output logic                          done,
   output logic                          busy,
   output logic [cnt_width(WIDTH)-1:0]   count,
   output logic [WIDTH-1:0]              data_out
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   state_t     state;
   fill_mode_t mode_q;
   logic       load_go;
   logic       shift_go;
   logic       out_bit;

   assign load_ready = (state == IDLE);
   assign busy       = (state == SHIFT);
   assign load_go    = (state == IDLE) && load_valid;
   assign shift_go   = (state == SHIFT) && shift_en && !abort;

   piso_serializer_shift_core #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_core (
      .clk       (clk),
      .rst_b     (rst_b),
      .load_en   (load_go),
      .shift_en  (shift_go),
      .data_in   (data_in),
      .fill_mode (mode_q),
      .ser_in    (ser_in),
      .data_out  (data_out),
      .out_bit   (out_bit)
   );

   // Control FSM with registered serial outputs and bit counter.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         mode_q    <= MODE_LOGIC;
         count     <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         bit_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  mode_q <= fill_mode_t'(mode);
                  count  <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (abort) begin
                  count <= '0;
                  state <= IDLE;
               end else if (shift_en) begin
                  bit_out   <= out_bit;
                  bit_valid <= 1'b1;
                  count     <= count + ONE;
                  if (count == LAST_CNT) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance share stimulus;
// a select picks which one's outputs are compared.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic [1:0] mode = '0;
   logic       ser_in = 1'b0;
   logic       shift_en = 1'b0;
   logic       abort = 1'b0;

   logic       l_ready, l_bit, l_valid, l_done, l_busy;
   logic [3:0] l_count;
   logic [7:0] l_dout;
   logic       m_ready, m_bit, m_valid, m_done, m_busy;
   logic [3:0] m_count;
   logic [7:0] m_dout;

   logic       sel_m = 1'b0;
   logic       o_ready, o_bit, o_valid, o_done, o_busy;
   logic [3:0] o_count;
   logic [7:0] o_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_b(rst_b), .load_valid(load_valid), .load_ready(l_ready),
      .data_in(data_in), .mode(mode), .ser_in(ser_in), .shift_en(shift_en),
      .abort(abort), .bit_out(l_bit), .bit_valid(l_valid), .done(l_done),
      .busy(l_busy), .count(l_count), .data_out(l_dout));

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst_b(rst_b), .load_valid(load_valid), .load_ready(m_ready),
      .data_in(data_in), .mode(mode), .ser_in(ser_in), .shift_en(shift_en),
      .abort(abort), .bit_out(m_bit), .bit_valid(m_valid), .done(m_done),
      .busy(m_busy), .count(m_count), .data_out(m_dout));

   assign o_ready = sel_m ? m_ready : l_ready;
   assign o_bit   = sel_m ? m_bit   : l_bit;
   assign o_valid = sel_m ? m_valid : l_valid;
   assign o_done  = sel_m ? m_done  : l_done;
   assign o_busy  = sel_m ? m_busy  : l_busy;
   assign o_count = sel_m ? m_count : l_count;
   assign o_dout  = sel_m ? m_dout  : l_dout;

   typedef struct {
      logic [7:0] data;
      logic [1:0] md;
      logic       ser;
      logic [7:0] exp_bits;   // bit i = i-th emitted bit
      logic [7:0] exp_dout;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_word(input bit m, input logic [7:0] d, input logic [1:0] md,
                           input logic s, input logic [7:0] eb, input logic [7:0] ed,
                           input string tag);
      sel_m = m;
      load_valid = 1'b1; data_in = d; mode = md; ser_in = s; shift_en = 1'b0;
      step();
      chk({tag, "_busy"}, 32'(o_busy), 1);
      chk({tag, "_ready"}, 32'(o_ready), 0);
      chk({tag, "_count0"}, 32'(o_count), 0);
      load_valid = 1'b0; shift_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk({tag, "_valid"}, 32'(o_valid), 1);
         chk({tag, "_bit"}, 32'(o_bit), 32'(eb[i]));
         chk({tag, "_done"}, 32'(o_done), 32'(i == 7));
         chk({tag, "_count"}, 32'(o_count), 32'(i + 1));
      end
      shift_en = 1'b0;
      chk({tag, "_dout"}, 32'(o_dout), 32'(ed));
      chk({tag, "_ready_after"}, 32'(o_ready), 1);
      step();
      chk({tag, "_valid_idle"}, 32'(o_valid), 0);
      chk({tag, "_done_idle"}, 32'(o_done), 0);
      chk({tag, "_count_held"}, 32'(o_count), 8);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{data: 8'hA5, md: 2'b00, ser: 1'b0, exp_bits: 8'hA5, exp_dout: 8'h00};
      vecs[1] = '{data: 8'hA5, md: 2'b10, ser: 1'b0, exp_bits: 8'hA5, exp_dout: 8'hA5};
      vecs[2] = '{data: 8'h80, md: 2'b01, ser: 1'b0, exp_bits: 8'h80, exp_dout: 8'hFF};
      vecs[3] = '{data: 8'h5A, md: 2'b11, ser: 1'b1, exp_bits: 8'h5A, exp_dout: 8'h00};
      vecs[4] = '{data: 8'h3C, md: 2'b00, ser: 1'b1, exp_bits: 8'h3C, exp_dout: 8'hFF};

      // Reset values
      #12;
      chk("rst_dout", 32'(l_dout), 0);
      chk("rst_bit", 32'(l_bit), 0);
      chk("rst_valid", 32'(l_valid), 0);
      chk("rst_done", 32'(l_done), 0);
      chk("rst_count", 32'(l_count), 0);
      chk("rst_busy", 32'(l_busy), 0);
      chk("rst_ready", 32'(l_ready), 1);
      rst_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_busy", 32'(l_busy), 0);
      end

      // Table-driven words, LSB first
      for (int v = 0; v < 5; v++)
         run_word(1'b0, vecs[v].data, vecs[v].md, vecs[v].ser,
                  vecs[v].exp_bits, vecs[v].exp_dout, $sformatf("vec%0d", v));

      // MSB first, arithmetic mode fills zero: bits 1,0,0,0,0,0,0,1
      run_word(1'b1, 8'h81, 2'b01, 1'b0, 8'h81, 8'h00, "msb_arith");
      sel_m = 1'b0;

      // Stall: shift_en 1,0,0,1,0,0,... on word 0x3C
      begin
         logic [7:0] eb;
         logic       applied;
         int         nv;
         eb = 8'h3C;
         nv = 0;
         load_valid = 1'b1; data_in = 8'h3C; mode = 2'b00; ser_in = 1'b0; shift_en = 1'b0;
         step();
         load_valid = 1'b0;
         for (int c = 0; c < 40 && nv < 8; c++) begin
            applied = (c % 3 == 0);
            shift_en = applied;
            step();
            chk("stall_valid", 32'(l_valid), 32'(applied));
            if (applied) begin
               chk("stall_bit", 32'(l_bit), 32'(eb[nv]));
               chk("stall_done", 32'(l_done), 32'(nv == 7));
               nv++;
            end else begin
               chk("stall_done_low", 32'(l_done), 0);
            end
         end
         shift_en = 1'b0;
         chk("stall_nbits", 32'(nv), 8);
         chk("stall_dout", 32'(l_dout), 0);
         step();
      end

      // Abort after 3 bits with load_valid held high throughout SHIFT
      load_valid = 1'b1; data_in = 8'hFF; mode = 2'b00; ser_in = 1'b0; shift_en = 1'b0;
      step();
      data_in = 8'h00; shift_en = 1'b1;
      step();
      chk("ignore_load_dout", 32'(l_dout), 8'h7F);
      chk("ignore_load_ready", 32'(l_ready), 0);
      step();
      step();
      chk("pre_abort_count", 32'(l_count), 3);
      chk("pre_abort_dout", 32'(l_dout), 8'h1F);
      load_valid = 1'b0; abort = 1'b1;
      step();
      chk("abort_valid", 32'(l_valid), 0);
      chk("abort_done", 32'(l_done), 0);
      chk("abort_count", 32'(l_count), 0);
      chk("abort_dout", 32'(l_dout), 8'h1F);
      chk("abort_ready", 32'(l_ready), 1);

      // Abort in IDLE does not block a simultaneous load
      load_valid = 1'b1; data_in = 8'h55; shift_en = 1'b0;
      step();
      chk("idle_abort_busy", 32'(l_busy), 1);
      chk("idle_abort_dout", 32'(l_dout), 8'h55);
      load_valid = 1'b0;
      step();
      chk("abort_again_busy", 32'(l_busy), 0);
      abort = 1'b0;

      // Async reset mid-word
      load_valid = 1'b1; data_in = 8'hF0; mode = 2'b00; ser_in = 1'b0;
      step();
      load_valid = 1'b0; shift_en = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_count", 32'(l_count), 4);
      #2 rst_b = 1'b0;
      #1;
      chk("arst_dout", 32'(l_dout), 0);
      chk("arst_count", 32'(l_count), 0);
      chk("arst_valid", 32'(l_valid), 0);
      chk("arst_busy", 32'(l_busy), 0);
      chk("arst_ready", 32'(l_ready), 1);
      #1 rst_b = 1'b1;
      shift_en = 1'b0;
      step();
      chk("arst_no_done", 32'(l_done), 0);
      run_word(1'b0, 8'h01, 2'b00, 1'b0, 8'h01, 8'h00, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
